// File: rtl/draw_arbiter.sv
// rtl/draw_arbiter.sv - draw request arbiter/sequencer for the superpixel writer; optional DRAW_ARB_RR_EN selects round-robin
module draw_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int SPIXEL_X_WIDTH = 5,
    parameter int SPIXEL_Y_WIDTH = 5,
    parameter int COLOR_ID_WIDTH = 8,
    parameter int DONE_TIMEOUT   = 20000
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_REQ-1:0]                  req_vld,
    input  logic [NUM_REQ*SPIXEL_X_WIDTH-1:0]   req_x,
    input  logic [NUM_REQ*SPIXEL_Y_WIDTH-1:0]   req_y,
    input  logic [NUM_REQ*COLOR_ID_WIDTH-1:0]   req_color,
    output logic [NUM_REQ-1:0]                  req_ack,
    output logic [NUM_REQ-1:0]                  req_done,
    output logic [SPIXEL_X_WIDTH-1:0]           dp_x,
    output logic [SPIXEL_Y_WIDTH-1:0]           dp_y,
    output logic [COLOR_ID_WIDTH-1:0]           dp_data,
    output logic                                dp_vld,
    input  logic                                dp_done,
    output logic                                busy,
    output logic                                timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(DONE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DONE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [IDX_W-1:0]            gnt_q, gnt_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [SPIXEL_X_WIDTH-1:0]   dp_x_q, dp_x_d;
    logic [SPIXEL_Y_WIDTH-1:0]   dp_y_q, dp_y_d;
    logic [COLOR_ID_WIDTH-1:0]   dp_data_q, dp_data_d;
    logic                        dp_vld_q, dp_vld_d;
    logic [NUM_REQ-1:0]          req_ack_q, req_ack_d;
    logic [NUM_REQ-1:0]          req_done_q, req_done_d;
    logic                        busy_q, busy_d;
    logic                        timeout_q, timeout_d;

    logic [IDX_W-1:0]            win_idx;

`ifdef DRAW_ARB_RR_EN
    logic [IDX_W-1:0]            ptr_q, ptr_d;
    int                          cand;

    // Round-robin winner: scan from the slot after the last grant, wrapping once
    always_comb begin
        win_idx = '0;
        cand    = 0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = (int'(ptr_q) + off) % NUM_REQ;
            if (req_vld[cand]) begin
                win_idx = IDX_W'(cand);
            end
        end
    end
`else
    // Fixed-priority winner: lowest asserted index
    always_comb begin
        win_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_vld[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end
`endif

    // Next-state and registered-output logic for IDLE -> ISSUE -> WAIT sequencing
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        cnt_d      = cnt_q;
        dp_x_d     = dp_x_q;
        dp_y_d     = dp_y_q;
        dp_data_d  = dp_data_q;
        dp_vld_d   = 1'b0;
        req_ack_d  = '0;
        req_done_d = '0;
        timeout_d  = 1'b0;
`ifdef DRAW_ARB_RR_EN
        ptr_d      = ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|req_vld) begin
                    state_d   = ST_ISSUE;
                    gnt_d     = win_idx;
                    dp_x_d    = req_x[int'(win_idx) * SPIXEL_X_WIDTH +: SPIXEL_X_WIDTH];
                    dp_y_d    = req_y[int'(win_idx) * SPIXEL_Y_WIDTH +: SPIXEL_Y_WIDTH];
                    dp_data_d = req_color[int'(win_idx) * COLOR_ID_WIDTH +: COLOR_ID_WIDTH];
                    dp_vld_d  = 1'b1;
                    req_ack_d = NUM_REQ'(1) << win_idx;
`ifdef DRAW_ARB_RR_EN
                    ptr_d     = win_idx;
`endif
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                // A completion on the expiry cycle wins over the timeout
                if (dp_done) begin
                    state_d    = ST_IDLE;
                    req_done_d = NUM_REQ'(1) << gnt_q;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = ST_IDLE;
                    req_done_d = NUM_REQ'(1) << gnt_q;
                    timeout_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset clears everything including an in-flight draw
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            cnt_q      <= '0;
            dp_x_q     <= '0;
            dp_y_q     <= '0;
            dp_data_q  <= '0;
            dp_vld_q   <= 1'b0;
            req_ack_q  <= '0;
            req_done_q <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            cnt_q      <= cnt_d;
            dp_x_q     <= dp_x_d;
            dp_y_q     <= dp_y_d;
            dp_data_q  <= dp_data_d;
            dp_vld_q   <= dp_vld_d;
            req_ack_q  <= req_ack_d;
            req_done_q <= req_done_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
        end
    end

`ifdef DRAW_ARB_RR_EN
    // Round-robin pointer; starting at the last index makes requester 0 first after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign req_ack  = req_ack_q;
    assign req_done = req_done_q;
    assign dp_x     = dp_x_q;
    assign dp_y     = dp_y_q;
    assign dp_data  = dp_data_q;
    assign dp_vld   = dp_vld_q;
    assign busy     = busy_q;
    assign timeout  = timeout_q;

endmodule
